// File: rtl/nonce_scanner.sv
// Mining-loop controller: streams a nonce-patched message block into the SHA-256
// accelerator, collects the 8 result words and sweeps nonces until hash < target.
module nonce_scanner #(
    parameter int NONCE_WORD = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic         abort,
    input  logic [511:0] msg_tmpl,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         acc_cs,
    output logic         acc_write,
    output logic [4:0]   acc_address,
    output logic [31:0]  acc_writedata,
    input  logic [31:0]  acc_data,
    input  logic [3:0]   acc_waddr,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  golden_nonce,
    output logic [255:0] hash_out,
    output logic         timeout_err,
    output logic [2:0]   dbg_state
);

    // Handshake: go is a one-cycle request taken only in IDLE with abort low; done is a
    // one-cycle response, and found/golden_nonce/hash_out hold from then until the next taken go.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_CMP   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t         r_state;
    logic [511:0]   r_tmpl;
    logic [255:0]   r_target;
    logic [255:0]   r_hash;
    logic [31:0]    r_nonce;
    logic [31:0]    r_nonce_end;
    logic [7:0]     r_mask;
    logic [TW-1:0]  r_tcnt;
    logic           r_miss;

    logic           w_cap;
    logic [7:0]     w_mask_nxt;
    logic           w_full;
    logic           w_tmo;
    logic           w_hit;
    logic           w_last;
    logic [31:0]    w_nonce_inc;

    function automatic logic [31:0] blk_word(input logic [511:0] tmpl, input logic [3:0] idx,
                                             input logic [31:0] nonce);
        if (idx == 4'(NONCE_WORD)) return nonce;
        return tmpl[{idx, 5'd0} +: 32];
    endfunction

    assign w_cap       = ~acc_waddr[3];
    assign w_mask_nxt  = r_mask | (w_cap ? (8'h01 << acc_waddr[2:0]) : 8'h00);
    assign w_full      = (w_mask_nxt == 8'hFF);
    assign w_tmo       = (r_tcnt >= TLAST);
    // A timed-out attempt holds an incomplete hash, so it can never count as a hit.
    assign w_hit       = ~r_miss && (r_hash < r_target);
    assign w_last      = (r_nonce == r_nonce_end);
    assign w_nonce_inc = r_nonce + 32'd1;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_tmpl        <= '0;
            r_target      <= '0;
            r_hash        <= '0;
            r_nonce       <= '0;
            r_nonce_end   <= '0;
            r_mask        <= '0;
            r_tcnt        <= '0;
            r_miss        <= 1'b0;
            acc_cs        <= 1'b0;
            acc_write     <= 1'b0;
            acc_address   <= '0;
            acc_writedata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            golden_nonce  <= '0;
            hash_out      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((r_state == S_WAIT || r_state == S_DRAIN) && w_cap) begin
                r_hash[{acc_waddr[2:0], 5'd0} +: 32] <= acc_data;
                r_mask <= w_mask_nxt;
            end
            case (r_state)
                S_IDLE: begin
                    if (go && !abort) begin
                        r_state       <= S_LOAD;
                        r_tmpl        <= msg_tmpl;
                        r_target      <= target;
                        r_nonce_end   <= nonce_end;
                        r_nonce       <= nonce_start;
                        busy          <= 1'b1;
                        found         <= 1'b0;
                        timeout_err   <= 1'b0;
                        acc_cs        <= 1'b1;
                        acc_write     <= 1'b1;
                        acc_address   <= 5'd0;
                        acc_writedata <= blk_word(msg_tmpl, 4'd0, nonce_start);
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state       <= S_IDLE;
                        busy          <= 1'b0;
                        acc_cs        <= 1'b0;
                        acc_write     <= 1'b0;
                        acc_address   <= '0;
                        acc_writedata <= '0;
                    end else if (acc_address == 5'd15) begin
                        r_state       <= S_START;
                        acc_address   <= 5'd16;
                        acc_writedata <= 32'hFFFF_FFFF;
                    end else begin
                        acc_address   <= acc_address + 5'd1;
                        acc_writedata <= blk_word(r_tmpl, acc_address[3:0] + 4'd1, r_nonce);
                    end
                end
                S_START: begin
                    acc_cs        <= 1'b0;
                    acc_write     <= 1'b0;
                    acc_address   <= '0;
                    acc_writedata <= '0;
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                        r_mask  <= '0;
                        r_tcnt  <= '0;
                        r_miss  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (abort) begin
                        r_state <= S_DRAIN;
                    end else if (w_full) begin
                        r_state <= S_CMP;
                    end else if (w_tmo) begin
                        timeout_err <= 1'b1;
                        r_miss      <= 1'b1;
                        r_state     <= S_CMP;
                    end
                end
                S_CMP: begin
                    hash_out     <= r_hash;
                    golden_nonce <= r_nonce;
                    if (w_hit || w_last) begin
                        found   <= w_hit;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_nonce       <= w_nonce_inc;
                        r_state       <= S_LOAD;
                        acc_cs        <= 1'b1;
                        acc_write     <= 1'b1;
                        acc_address   <= 5'd0;
                        acc_writedata <= blk_word(r_tmpl, 4'd0, w_nonce_inc);
                    end
                end
                S_DRAIN: begin
                    // Let the accelerator finish its result burst so the next sweep starts clean.
                    r_tcnt <= r_tcnt + TW'(1);
                    if (w_full || w_tmo) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        if (!w_full) timeout_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/nonce_scanner.md
# nonce_scanner

Mining-loop controller that sits directly upstream of the Avalon SHA-256 accelerator slave and also consumes its hash output.
- Per nonce, it writes a 16-word message block into the accelerator, with the current nonce substituted into one word, then issues the start command.
- It captures the 8 returned hash words and compares the 256-bit hash against a target.
- It sweeps a nonce range until it finds a hit or exhausts the range, then reports the result to the host-side register block.

## Interface
Parameters:
- NONCE_WORD, 3: message word index (0-15) replaced by the current nonce.
- TIMEOUT, 4096: maximum cycles spent in WAIT before the attempt is abandoned.

Ports:
- clk  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle pulse that starts a sweep; ignored while busy=1.
- abort  in  1  level; stops the sweep (see Operation).
- msg_tmpl  in  512  message template; word i is bits [32i+31:32i].
- target  in  256  unsigned threshold; word 7 is the most significant.
- nonce_start  in  32  first nonce tried.
- nonce_end  in  32  last nonce tried (inclusive).
- acc_cs  out  1  accelerator chipselect.
- acc_write  out  1  accelerator write strobe.
- acc_address  out  5  accelerator word address (0-15 data, 16 control).
- acc_writedata  out  32  accelerator write data.
- acc_data  in  32  accelerator result word.
- acc_waddr  in  4  accelerator result tag. Bit 3 = 1 means idle. Otherwise bits [2:0] give the word index.
- busy  out  1  high from the cycle after an accepted go until done or abort completes.
- done  out  1  one-cycle pulse when a sweep ends normally.
- found  out  1  valid with done; 1 = hash < target.
- golden_nonce  out  32  nonce of the last compared attempt (the hit when found=1).
- hash_out  out  256  hash of the last compared attempt.
- timeout_err  out  1  sticky; set on any WAIT timeout; cleared by an accepted go.

## Operation
- msg_tmpl, target and nonce_end are sampled into internal registers when go is accepted. nonce_start loads the nonce register at the same time.
- State machine states: IDLE, LOAD, START, WAIT, CMP, DRAIN.
- IDLE -> LOAD: on go while idle.
- LOAD: 16 cycles, addresses 0..15 in order, acc_cs=acc_write=1.
  - acc_writedata is the template word.
  - At address NONCE_WORD, acc_writedata is the nonce instead.
- START: one cycle; address 16, data 32'hFFFFFFFF, acc_cs=acc_write=1. Then -> WAIT, clearing the capture mask and the timeout counter.
- WAIT capture: each cycle with acc_waddr[3]=0, acc_data is stored into hash word acc_waddr[2:0] and that bit of the 8-bit capture mask is set. A repeated index overwrites the stored word; the mask bit stays set.
- WAIT exits:
  - Mask = 8'hFF -> CMP.
  - Timeout counter reaches TIMEOUT -> set timeout_err, then proceed as if the compare missed. The nonce still advances.
- CMP, one cycle:
  - Update hash_out and golden_nonce.
  - If hash < target (strict, unsigned 256-bit): found=1, pulse done, -> IDLE.
  - Else, if nonce == nonce_end: found=0, pulse done, -> IDLE.
  - Else: nonce <= nonce+1 (mod 2^32), -> LOAD.
- Wrap-around: if nonce_end < nonce_start, the sweep passes 32'hFFFFFFFF -> 0 and continues to nonce_end. If nonce_start == nonce_end, exactly one attempt is made.
- abort:
  - In LOAD or START: -> IDLE next cycle, with no done pulse. A partial block write is acceptable.
  - In WAIT: -> DRAIN. DRAIN keeps capturing until mask = 8'hFF or timeout, then -> IDLE with no done, so the accelerator returns to idle before the next go.
  - In CMP: ignored.
- Simultaneous go and abort in IDLE: go is ignored.

## Timing
- Reset (asserted low): all outputs 0 and state IDLE. This includes acc_cs, acc_write, acc_address, acc_writedata, busy, done, found, golden_nonce, hash_out and timeout_err.
- All outputs are registered. acc_* outputs are 0 in IDLE, WAIT, CMP and DRAIN.
- go accepted at edge N: busy=1 and the first LOAD write (address 0) are presented in cycle N+1.
- Per-attempt overhead: 16 LOAD + 1 START + 1 CMP = 18 cycles, plus accelerator latency.
- done is asserted for exactly one cycle, the cycle after CMP. busy falls in that same cycle, and found, golden_nonce and hash_out are stable from that cycle until the next accepted go.
- Reset mid-sweep is immediate; no done pulse.

## Test plan
- Single nonce: nonce_start=nonce_end=5, target=all-ones. Bench accelerator returns hash 256'h1. Required: address 3 carries 5; done pulses once with found=1, golden_nonce=5.
- Miss sweep: range 10..12, target=0. Required: 3 LOAD/START sequences with nonces 10, 11, 12; done with found=0, golden_nonce=12.
- Hit mid-range: range 0..9, bench hash < target only for nonce 4. Required: stops after nonce 4; found=1, golden_nonce=4; nonces 5..9 are never written.
- Wrap: nonce_start=32'hFFFFFFFE, nonce_end=1. Required: nonces FFFFFFFE, FFFFFFFF, 0, 1, in that order.
- Out-of-order/duplicate capture: bench returns words 7,0,0,1..6 with the second word 0 changed. Required: CMP uses the final values; hash_out matches.
- Timeout and abort:
  - Bench withholds word 5: timeout_err=1 after TIMEOUT cycles, and the next nonce is loaded.
  - abort asserted in LOAD: no done; busy=0 the next cycle; acc_cs=0.
